// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - assembles received UART bytes into little/big-endian words
//
// Purpose:
//   Collects 1..WORD_BYTES bytes from a UART byte strobe into one word, with
//   selectable byte order. Completed words go to a one-deep output register
//   that uses a valid/ready handshake. A partial word is discarded if the
//   bytes stop arriving for TIMEOUT_CYCLES clocks (0 disables this).
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   byte_data    in   [7:0] received byte
//   byte_valid   in   single-cycle strobe qualifying byte_data
//   byte_len     in   [LW-1:0] bytes per word; 0 or >WORD_BYTES selects WORD_BYTES
//   big_endian   in   1 = first byte lands in the most significant position
//   word_data    out  [8*WORD_BYTES-1:0] assembled word
//   word_valid   out  word_data holds a word not yet taken
//   word_ready   in   consumer takes the word when word_valid & word_ready
//   busy         out  a word is partially collected
//   timeout_err  out  one-cycle pulse when a partial word is discarded
//   overrun_err  out  one-cycle pulse when a completed word is dropped

module uart_word_rx #(
  parameter int  WORD_BYTES     = 4,
  parameter int  TIMEOUT_CYCLES = 100000,
  localparam int LW             = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              byte_data,
  input  logic                    byte_valid,
  input  logic [LW-1:0]           byte_len,
  input  logic                    big_endian,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    overrun_err
);

  localparam int W = 8 * WORD_BYTES;
  localparam logic [LW-1:0] WB_L = LW'(WORD_BYTES);

  // The idle counter only has to reach TIMEOUT_CYCLES-1: expiry is detected
  // on the edge that would have taken it to TIMEOUT_CYCLES.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [LW-1:0] r_len;
  logic          r_be;
  logic [LW-1:0] r_count;
  logic [W-1:0]  r_asm;
  logic [CW-1:0] r_idle_cnt;
  logic [W-1:0]  r_word_data;
  logic          r_word_valid;
  logic          r_timeout_err;
  logic          r_overrun_err;

  logic [LW-1:0] w_eff_len;
  logic [LW-1:0] w_len_sel;
  logic          w_be_sel;
  logic [LW-1:0] w_idx;
  logic [LW-1:0] w_pos;
  logic [W-1:0]  w_base;
  logic [W-1:0]  w_asm_new;
  logic [LW-1:0] w_count_new;
  logic          w_complete;
  logic          w_timeout;
  logic          w_load;
  logic          w_overrun;

  // Out-of-range lengths fall back to a full-width word.
  always_comb begin
    w_eff_len = byte_len;
    if ((byte_len == '0) || (byte_len > WB_L)) begin
      w_eff_len = WB_L;
    end
  end

  // In IDLE the incoming byte starts a new word, so length and byte order
  // come straight from the inputs and the assembly register is treated as
  // empty. In COLLECT the values latched at the first byte are used, which
  // keeps mid-word changes of byte_len/big_endian from corrupting the word.
  always_comb begin
    w_len_sel = r_len;
    w_be_sel  = r_be;
    w_idx     = r_count;
    w_base    = r_asm;
    if (r_state == S_IDLE) begin
      w_len_sel = w_eff_len;
      w_be_sel  = big_endian;
      w_idx     = '0;
      w_base    = '0;
    end
    w_pos       = w_be_sel ? (w_len_sel - LW'(1) - w_idx) : w_idx;
    w_asm_new   = w_base | (W'(byte_data) << {w_pos, 3'b000});
    w_count_new = w_idx + LW'(1);
  end

  // Next-state logic. A byte arriving in the expiry cycle wins over the
  // timeout because the byte_valid branch is evaluated first.
  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (byte_valid) begin
          if (w_count_new == w_len_sel) begin
            w_complete   = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_COLLECT;
          end
        end else if ((r_state == S_COLLECT) && TO_EN && (r_idle_cnt == TO_LAST)) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // A completed word may enter the output register when it is empty or is
  // being emptied in this same cycle; otherwise it is dropped.
  assign w_load    = w_complete && (!r_word_valid || word_ready);
  assign w_overrun = w_complete && r_word_valid && !word_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len         <= '0;
      r_be          <= 1'b0;
      r_count       <= '0;
      r_asm         <= '0;
      r_idle_cnt    <= '0;
      r_word_data   <= '0;
      r_word_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (byte_valid) begin
        r_asm   <= w_asm_new;
        r_count <= w_count_new;
        if (r_state == S_IDLE) begin
          r_len <= w_eff_len;
          r_be  <= big_endian;
        end
      end
      if (w_complete || w_timeout) begin
        r_count <= '0;
      end

      if ((r_state == S_COLLECT) && !byte_valid && !w_timeout && TO_EN) begin
        r_idle_cnt <= r_idle_cnt + CW'(1);
      end else begin
        r_idle_cnt <= '0;
      end

      if (w_load) begin
        r_word_data  <= w_asm_new;
        r_word_valid <= 1'b1;
      end else if (word_ready) begin
        r_word_valid <= 1'b0;
      end

      r_timeout_err <= w_timeout;
      r_overrun_err <= w_overrun;
    end
  end

  assign word_data   = r_word_data;
  assign word_valid  = r_word_valid;
  assign busy        = (r_state == S_COLLECT);
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_word_rx.sv
// tb/tb_uart_word_rx.sv - directed self-checking bench for uart_word_rx

module tb_uart_word_rx;

  logic        clk;
  logic        reset;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [2:0]  byte_len;
  logic        big_endian;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        timeout_err;
  logic        overrun_err;

  int checks = 0;
  int errors = 0;
  int n_timeout = 0;
  int n_overrun = 0;

  uart_word_rx #(
    .WORD_BYTES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .byte_len(byte_len),
    .big_endian(big_endian),
    .word_data(word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .busy(busy),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timeout_err === 1'b1) n_timeout++;
    if (overrun_err === 1'b1) n_overrun++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Called at a negedge; the byte is sampled at the following posedge and
  // the task returns at the negedge after it, so consecutive calls give
  // back-to-back bytes and outputs of the completing edge are visible on return.
  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", word_valid); end
    checks++; if (word_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 00000000", word_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_tmo: got %b expected 0", timeout_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b expected 0", overrun_err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_little_endian();
    byte_len = 3'd4; big_endian = 1'b0; word_ready = 1'b1;
    send_byte(8'h11);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL le_busy: got %b expected 1", busy); end
    send_byte(8'h22);
    send_byte(8'h33);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL le_early_valid: got %b expected 0", word_valid); end
    send_byte(8'h44);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL le_valid: got %b expected 1", word_valid); end
    checks++; if (word_data !== 32'h44332211) begin errors++; $display("FAIL le_data: got %h expected 44332211", word_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL le_busy_done: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL le_taken: got %b expected 0", word_valid); end
  endtask

  task automatic test_big_endian();
    byte_len = 3'd4; big_endian = 1'b1; word_ready = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL be4_valid: got %b expected 1", word_valid); end
    checks++; if (word_data !== 32'h11223344) begin errors++; $display("FAIL be4_data: got %h expected 11223344", word_data); end
    @(negedge clk);
    // Length and byte order are changed after the first byte; the word must
    // still finish as a 2-byte big-endian word.
    byte_len = 3'd2; big_endian = 1'b1;
    send_byte(8'hAB);
    byte_len = 3'd4; big_endian = 1'b0;
    send_byte(8'hCD);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL be2_valid: got %b expected 1", word_valid); end
    checks++; if (word_data !== 32'h0000ABCD) begin errors++; $display("FAIL be2_data: got %h expected 0000abcd", word_data); end
    @(negedge clk);
  endtask

  task automatic test_len_default();
    byte_len = 3'd0; big_endian = 1'b0; word_ready = 1'b1;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    checks++; if (word_data !== 32'h04030201) begin errors++; $display("FAIL len0_data: got %h expected 04030201", word_data); end
    @(negedge clk);
    byte_len = 3'd7;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL len7_early: got %b expected 0", word_valid); end
    send_byte(8'hA4);
    checks++; if (word_data !== 32'hA4A3A2A1) begin errors++; $display("FAIL len7_data: got %h expected a4a3a2a1", word_data); end
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    byte_len = 3'd1; big_endian = 1'b0; word_ready = 1'b1;
    send_byte(8'h5A);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", word_valid); end
    checks++; if (word_data !== 32'h0000005A) begin errors++; $display("FAIL single_data: got %h expected 0000005a", word_data); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    byte_len = 3'd4; big_endian = 1'b0; word_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    if (timeout_err !== 1'b0) early++;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (timeout_err !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early: got %0d early pulses expected 0", early); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b expected 1", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL tmo_valid: got %b expected 0", word_valid); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_width: got %b expected 0", timeout_err); end
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
    checks++; if (word_data !== 32'h0D0C0B0A) begin errors++; $display("FAIL tmo_fresh: got %h expected 0d0c0b0a", word_data); end
    @(negedge clk);
  endtask

  task automatic test_timeout_boundary();
    byte_len = 3'd4; big_endian = 1'b0; word_ready = 1'b1;
    send_byte(8'h01);
    repeat (15) @(negedge clk);
    send_byte(8'h02);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmob_pulse: got %b expected 0", timeout_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmob_busy: got %b expected 1", busy); end
    send_byte(8'h03); send_byte(8'h04);
    checks++; if (word_data !== 32'h04030201) begin errors++; $display("FAIL tmob_data: got %h expected 04030201", word_data); end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    byte_len = 3'd4; big_endian = 1'b0; word_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b expected 0", overrun_err); end
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b expected 1", overrun_err); end
    checks++; if (word_data !== 32'h44332211) begin errors++; $display("FAIL ovr_held: got %h expected 44332211", word_data); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", word_valid); end
    @(negedge clk);
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_width: got %b expected 0", overrun_err); end
    word_ready = 1'b1;
    @(negedge clk);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", word_valid); end
  endtask

  task automatic test_back_to_back();
    byte_len = 3'd4; big_endian = 1'b0; word_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    word_ready = 1'b1;
    send_byte(8'h08);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", word_valid); end
    checks++; if (word_data !== 32'h08070605) begin errors++; $display("FAIL b2b_data: got %h expected 08070605", word_data); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b expected 0", overrun_err); end
    @(negedge clk);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL b2b_taken: got %b expected 0", word_valid); end
  endtask

  task automatic test_reset_mid();
    byte_len = 3'd4; big_endian = 1'b0; word_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    reset = 1'b1; byte_data = 8'h77; byte_valid = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; byte_valid = 1'b0;
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", word_valid); end
    checks++; if (word_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h expected 00000000", word_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    checks++; if (word_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL rmid_word: got %h expected ddccbbaa", word_data); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rmid_wvalid: got %b expected 1", word_valid); end
    checks++; if ((timeout_err | overrun_err) !== 1'b0) begin errors++; $display("FAIL rmid_err: got tmo=%b ovr=%b expected 0", timeout_err, overrun_err); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; byte_data = 8'h00; byte_valid = 1'b0;
    byte_len = 3'd4; big_endian = 1'b0; word_ready = 1'b1;
    test_reset();
    test_little_endian();
    test_big_endian();
    test_len_default();
    test_single_byte();
    test_timeout();
    test_timeout_boundary();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    repeat (20) @(negedge clk);
    checks++; if (n_timeout !== 1) begin errors++; $display("FAIL total_tmo: got %0d pulses expected 1", n_timeout); end
    checks++; if (n_overrun !== 1) begin errors++; $display("FAIL total_ovr: got %0d pulses expected 1", n_overrun); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_rx.md
UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 4, meaning maximum bytes per assembled word (1..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning inter-byte timeout in clk cycles; 0 disables timeout.
REQ-003 The block SHALL use derived width LW = clog2(WORD_BYTES+1) for byte_len.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port byte_data, input, 8, received UART byte.
REQ-007 The block SHALL have port byte_valid, input, 1, single-cycle strobe, byte_data valid.
REQ-008 The block SHALL have port byte_len, input, LW, bytes per word; 0 or >WORD_BYTES means WORD_BYTES.
REQ-009 The block SHALL have port big_endian, input, 1, 1 = first byte is most significant.
REQ-010 The block SHALL have port word_data, output, 8*WORD_BYTES, assembled word.
REQ-011 The block SHALL have port word_valid, output, 1, word_data holds an untaken word.
REQ-012 The block SHALL have port word_ready, input, 1, consumer accepts word when word_valid & word_ready.
REQ-013 The block SHALL have port busy, output, 1, high in COLLECT.
REQ-014 The block SHALL have port timeout_err, output, 1, one-cycle pulse on partial-word discard.
REQ-015 The block SHALL have port overrun_err, output, 1, one-cycle pulse on completed-word drop.

Function
REQ-016 The block SHALL implement states IDLE and COLLECT, plus a 1-deep output register independent of state.
REQ-017 In IDLE, on byte_valid, the block SHALL latch the effective length L and big_endian, clear the assembly register, store the byte as index 0, set count=1, and go to COLLECT (or complete at once if L=1).
REQ-018 In COLLECT, each byte_valid SHALL store the byte at index count and increment count; the byte making count=L SHALL complete the word and return to IDLE.
REQ-019 Little-endian placement SHALL put byte index k at bits [8k+7:8k]; big-endian SHALL put it at bits [8(L-1-k)+7:8(L-1-k)].
REQ-020 Bits above 8L in a completed word SHALL be zero.
REQ-021 byte_len and big_endian changes during COLLECT SHALL have no effect on the word in progress.
REQ-022 On completion, if word_valid=0 or word_ready=1 in that cycle, the word SHALL be loaded into word_data at that edge, and word_valid SHALL be 1 the following cycle.
REQ-023 On completion with word_valid=1 and word_ready=0, the new word SHALL be dropped, word_data held, and overrun_err pulsed the following cycle.
REQ-024 word_valid SHALL clear after an edge with word_valid & word_ready unless a completion loads a new word at that same edge.
REQ-025 In COLLECT, an idle counter SHALL reset on every byte_valid and increment otherwise; reaching TIMEOUT_CYCLES SHALL discard the partial word, return to IDLE, and pulse timeout_err for one cycle.
REQ-026 byte_valid in the cycle the counter would expire SHALL be accepted as data; no timeout occurs.
REQ-027 Completion latency SHALL be one cycle: word_valid rises on the cycle after the final byte_valid.

Reset
REQ-028 Reset SHALL force IDLE, count=0, idle counter=0, word_data=0, word_valid=0, busy=0, timeout_err=0, overrun_err=0.
REQ-029 Reset asserted mid-COLLECT or with word_valid=1 SHALL discard all partial and pending data without error pulses.
REQ-030 Reset SHALL take precedence over simultaneous byte_valid and word_ready.

Verification
REQ-031 Bench: WORD_BYTES=4, byte_len=4, big_endian=0, bytes 11,22,33,44 with word_ready=1 -> word_data=0x44332211, word_valid one cycle after byte 44.
REQ-032 Bench: byte_len=4, big_endian=1, bytes 11,22,33,44 -> word_data=0x11223344; byte_len=2, big_endian=1, bytes AB,CD -> 0x0000ABCD.
REQ-033 Bench: byte_len=1, byte 5A -> word_data=0x0000005A, busy never high, word_valid next cycle.
REQ-034 Bench: TIMEOUT_CYCLES=16, bytes 01,02 then silence -> timeout_err pulse 16 cycles after byte 02, no word_valid; next bytes start a fresh word.
REQ-035 Bench: word_ready=0, two full 4-byte words -> first word held, overrun_err pulse after second completion, word_data unchanged.
REQ-036 Bench: reset after 2 of 4 bytes, then 4 new bytes AA,BB,CC,DD -> word_data=0xDDCCBBAA, no error pulses.
